// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_if.sv
// Request/response bundle between the ALU and the shift sequencer.
interface shift_seq_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/shift_step.sv
// One-bit shift stage used once per cycle by shift_seq.
// Rotate-right is only present when SHIFT_ROR_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] q_o
);

  // single-step shift selected by the latched operation
  always_comb begin
    q_o = d_i;
    case (op_i)
      OP_SLL:  q_o = {d_i[WIDTH-2:0], 1'b0};
      OP_SRL:  q_o = {1'b0, d_i[WIDTH-1:1]};
      OP_SRA:  q_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
`ifdef SHIFT_ROR_EN
      OP_ROR:  q_o = {d_i[0], d_i[WIDTH-1:1]};
`endif
      default: q_o = d_i;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: start/busy/done handshake, one bit shifted per cycle.
// Optional feature: SHIFT_ROR_EN enables rotate-right for op 2'b11 (otherwise pass-through).
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  shift_seq_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] result_q;
  logic [SHW-1:0]   cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [SHW-1:0]   cnt_load_d;
  logic [WIDTH-1:0] step_d;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d_i  (shreg_q),
    .op_i (op_q),
    .q_o  (step_d)
  );

  // shift count taken on acceptance; pass-through requests skip straight to DONE
  always_comb begin
    cnt_load_d = bus.b;
`ifndef SHIFT_ROR_EN
    if (bus.op == OP_ROR) begin
      cnt_load_d = {SHW{1'b0}};
    end else begin
      cnt_load_d = bus.b;
    end
`endif
  end

  // sequencer FSM with registered busy/done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_SLL;
      shreg_q  <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      cnt_q    <= {SHW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            shreg_q <= bus.a;
            op_q    <= op_e'(bus.op);
            cnt_q   <= cnt_load_d;
            busy_q  <= 1'b1;
            if (cnt_load_d != {SHW{1'b0}}) begin
              state_q <= S_SHIFT;
              done_q  <= 1'b0;
            end else begin
              result_q <= bus.a;
              state_q  <= S_DONE;
              done_q   <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          shreg_q <= step_d;
          cnt_q   <= cnt_q - CNT_ONE;
          busy_q  <= 1'b1;
          if (cnt_q == CNT_ONE) begin
            result_q <= step_d;
            state_q  <= S_DONE;
            done_q   <= 1'b1;
          end else begin
            done_q <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: vector table plus hand-written corner sequences.
module tb_shift_seq;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [4:0]   b;
    logic [W-1:0] exp_res;
    int           exp_lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           start_cyc;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  sb_t  sb_q[$];
  vec_t vecs[$];

  shift_seq_if #(.WIDTH(W)) bus ();

  shift_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive a request so that it is sampled at the next rising edge (edge 0); push expectation.
  task automatic start_req(input logic [1:0] op, input logic [W-1:0] a, input logic [4:0] b,
                           input logic [W-1:0] exp_res, input int exp_lat);
    sb_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    e.res = exp_res; e.lat = exp_lat; e.start_cyc = cyc;
    sb_q.push_back(e);
    bus.start = 1'b0; bus.a = $urandom; bus.b = 5'($urandom); bus.op = 2'($urandom);
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
  endtask

  // Wait (bounded) for done, compare with the scoreboard, then check busy falls next edge.
  task automatic wait_done(input string name);
    sb_t e;
    int guard = 0;
    while (!bus.done && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check({name, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, "_result"}, bus.result, e.res);
      check({name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
    end else begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end
    @(posedge clk);
    #1;
    check({name, "_busy_fall"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    vecs.push_back('{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 4});
    vecs.push_back('{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 4});
    vecs.push_back('{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 31});
    vecs.push_back('{2'b10, 32'h1234_5678, 5'd0,  32'h1234_5678, 0});
    vecs.push_back('{2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 31});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 31});
    vecs.push_back('{2'b00, 32'hA5A5_A5A5, 5'd1,  32'h4B4B_4B4A, 1});
    vecs.push_back('{2'b10, 32'h4000_0000, 5'd3,  32'h0800_0000, 3});
`ifdef SHIFT_ROR_EN
    vecs.push_back('{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 1});
    vecs.push_back('{2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F, 4});
`else
    vecs.push_back('{2'b11, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 0});
    vecs.push_back('{2'b11, 32'h0000_0001, 5'd31, 32'h0000_0001, 0});
`endif

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h1111_1111; bus.b = 5'd0;
    @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b0;

    foreach (vecs[i]) begin
      start_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);
      wait_done($sformatf("vec%0d", i));
    end

    // n=0 request immediately followed by one accepted at edge 2
    start_req(2'b10, 32'h1234_5678, 5'd0, 32'h1234_5678, 0);
    wait_done("b0_first");
    start_req(2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 2);
    wait_done("b0_next");

    // start pulse mid-operation must be ignored
    start_req(2'b01, 32'hFFFF_0000, 5'd8, 32'h00FF_FF00, 8);
    @(negedge clk); @(negedge clk); @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd0; bus.b = 5'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("ignore_start");

    // reset at edge 3 aborts without a done pulse
    start_req(2'b00, 32'h0000_0001, 5'd10, 32'h0, 0);
    void'(sb_q.pop_back());
    @(negedge clk); @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    begin
      int done_cnt = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk);
        #1;
        if (bus.done) done_cnt++;
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);
    end
    start_req(2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 2);
    wait_done("after_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer for the ALU shift path. It accepts a shift request (logical left, logical right or arithmetic right) through a start/busy/done handshake and steps a one-bit shift stage once per cycle under a down-counter. It replaces a full barrel shifter where area matters and feeds its registered result back to the ALU result mux.

## Interface
- WIDTH, 32, data width; shift amount width SHW = $clog2(WIDTH) is derived, not set.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  shift operation (encodings in shift_pkg).
- a  input  WIDTH  operand to shift.
- b  input  SHW  shift amount n; the range 0..WIDTH-1 is implicit from the port width.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  registered result; holds until the next completion.

## Operation
- States:
  - IDLE: waits for a request.
  - SHIFT: performs one step per cycle.
  - DONE: asserts done for one cycle.
- IDLE with start=1:
  - load shreg=a, cnt=b, latch op.
  - go to SHIFT if b!=0, else go to DONE with result=a.
- SHIFT, each edge:
  - shreg = step(shreg, op) and cnt = cnt-1.
  - when cnt==1, the edge also writes result=step(shreg, op) and moves to DONE.
- DONE: go to IDLE on the next edge unconditionally.
- Step rules:
  - SLL: shift left, fill bit 0 with 0.
  - SRL: shift right, fill the MSB with 0.
  - SRA: shift right, fill the MSB with the current shreg MSB, so the sign of a is replicated n times.
- Outputs: busy = (state!=IDLE); done = (state==DONE).
- start is ignored in SHIFT and DONE. a, b and op may change freely after acceptance.
- Reset values:
  - state=IDLE, busy=0, done=0, result=0, shreg=0, cnt=0.
  - reset takes priority over start on the same edge.
- Reset mid-operation: IDLE after that edge, result=0, and no done pulse for the aborted request.

## Timing
- Edge 0 is the edge at which start is sampled high in IDLE. busy is high from edge 0 on.
- Shifts occur at edges 1..n. result is written and DONE is entered at edge max(n,0); for n=0 that is edge 0 itself.
- done is high for exactly the cycle between edge n and edge n+1. result is valid from edge n.
- busy falls at edge n+1. The earliest next accept is edge n+2, so throughput is one request per n+2 cycles.
- Worst case (n=WIDTH-1=31): done in the cycle after edge 31.

## Configuration
- SHIFT_ROR_EN defined:
  - op=2'b11 is rotate right: bit 0 moves into the MSB each step.
  - full n-cycle latency, same rules as the other ops.
- SHIFT_ROR_EN undefined:
  - op=2'b11 is treated as a pass-through.
  - cnt is forced to 0 on acceptance, so the block goes straight to DONE with result=a and done in the cycle after edge 0, regardless of b.

## Structure
- Package shift_pkg:
  - op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11.
  - state encodings: S_IDLE, S_SHIFT, S_DONE.
- Sub-module shift_step: purely combinational one-bit shift of WIDTH bits by op; includes the ROR branch only under SHIFT_ROR_EN.
- shift_seq holds the FSM, counter, shreg and result register.

## Test plan
- SRA, a=32'h8000_0000, b=4 -> result=32'hF800_0000; done high only in the cycle after edge 4; busy high from edge 0 through edge 4.
- SRL, same a and b -> result=32'h0800_0000. SLL, a=32'h0000_0001, b=31 -> result=32'h8000_0000, done after edge 31.
- SRA, a=32'h1234_5678, b=0 -> result=32'h1234_5678, done in the cycle after edge 0; next start is accepted at edge 2.
- During SRL (a=32'hFFFF_0000, b=8), pulse start with a=0, b=1 at edge 3 -> ignored; result=32'h00FF_FF00 after edge 8.
- Reset at edge 3 of an SLL with b=10 -> IDLE, busy=0, result=0, no done. A fresh SLL (a=1, b=2) then gives result=4.
- With SHIFT_ROR_EN: op=3, a=32'h0000_0001, b=1 -> result=32'h8000_0000. Without it: op=3, a=32'hDEAD_BEEF, b=5 -> result=32'hDEAD_BEEF, done after edge 0.
